// File: rtl/gradient_bin.sv
// 3x3 central-difference gradient with |gx|+|gy| magnitude and 9-way orientation bin; 2-cycle latency.
// Valid/ready on both sides; a stalled output holds S2, S1 fills once, then k_ready drops.
module gradient_bin #(
   parameter int PIXEL_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       k_valid,
   output logic                       k_ready,
   input  logic [9*PIXEL_WIDTH-1:0]   kernel,
   input  logic                       k_border,
   output logic                       g_valid,
   input  logic                       g_ready,
   output logic [PIXEL_WIDTH:0]       g_gx,
   output logic [PIXEL_WIDTH:0]       g_gy,
   output logic [PIXEL_WIDTH:0]       g_mag,
   output logic [3:0]                 g_bin,
   output logic [15:0]                border_cnt
);

   localparam int W  = PIXEL_WIDTH + 1;
   localparam int PP = (PIXEL_WIDTH + 12 > 20) ? PIXEL_WIDTH + 12 : 20;

   logic                    s1_vld_q, s1_vld_d;
   logic signed [W-1:0]     s1_gx_q, s1_gx_d, s1_gy_q, s1_gy_d;
   logic                    s2_vld_q, s2_vld_d;
   logic signed [W-1:0]     s2_gx_q, s2_gx_d, s2_gy_q, s2_gy_d;
   logic [W-1:0]            s2_mag_q, s2_mag_d;
   logic [3:0]              s2_bin_q, s2_bin_d;
   logic [15:0]             border_cnt_q, border_cnt_d;

   logic                    s1_adv, k_fire;
   logic [PIXEL_WIDTH-1:0]  p10, p12, p01, p21;
   logic signed [W-1:0]     gx_in, gy_in;
   logic signed [W-1:0]     nx, ny, fx, fy, nfx;
   logic [PIXEL_WIDTH-1:0]  ax, ay;
   logic [PP-1:0]           lhs;
   logic [2:0]              cnt;
   logic [W-1:0]            mag_c;
   logic [3:0]              bin_c;
   logic                    unused_px;

   assign p10 = kernel[3*PIXEL_WIDTH +: PIXEL_WIDTH];
   assign p12 = kernel[5*PIXEL_WIDTH +: PIXEL_WIDTH];
   assign p01 = kernel[1*PIXEL_WIDTH +: PIXEL_WIDTH];
   assign p21 = kernel[7*PIXEL_WIDTH +: PIXEL_WIDTH];
   assign unused_px = ^{kernel[0 +: PIXEL_WIDTH], kernel[2*PIXEL_WIDTH +: PIXEL_WIDTH],
                        kernel[4*PIXEL_WIDTH +: PIXEL_WIDTH], kernel[6*PIXEL_WIDTH +: PIXEL_WIDTH],
                        kernel[8*PIXEL_WIDTH +: PIXEL_WIDTH]};

   assign gx_in = $signed({1'b0, p12}) - $signed({1'b0, p10});
   assign gy_in = $signed({1'b0, p21}) - $signed({1'b0, p01});

   assign s1_adv  = !s2_vld_q || g_ready;
   assign k_ready = !s1_vld_q || s1_adv;
   assign k_fire  = k_valid && k_ready;

   // Fold into the upper half-plane, then count tangent thresholds crossed.
   always_comb begin
      nx    = -s1_gx_q;
      ny    = -s1_gy_q;
      fx    = s1_gy_q[W-1] ? nx : s1_gx_q;
      fy    = s1_gy_q[W-1] ? ny : s1_gy_q;
      nfx   = -fx;
      ax    = fx[W-1] ? nfx[PIXEL_WIDTH-1:0] : fx[PIXEL_WIDTH-1:0];
      ay    = fy[PIXEL_WIDTH-1:0];
      lhs   = PP'(ay) << 8;
      cnt   = 3'd0;
      if (lhs >= PP'(ax) * PP'(93))   cnt = cnt + 3'd1;
      if (lhs >= PP'(ax) * PP'(215))  cnt = cnt + 3'd1;
      if (lhs >= PP'(ax) * PP'(443))  cnt = cnt + 3'd1;
      if (lhs >= PP'(ax) * PP'(1452)) cnt = cnt + 3'd1;
      mag_c = {1'b0, ax} + {1'b0, ay};
      if (ax == '0 && ay == '0)
         bin_c = 4'd0;
      else if (fx[W-1])
         bin_c = 4'd8 - {1'b0, cnt};
      else
         bin_c = {1'b0, cnt};
   end

   always_comb begin
      s1_vld_d     = s1_vld_q;
      s1_gx_d      = s1_gx_q;
      s1_gy_d      = s1_gy_q;
      s2_vld_d     = s2_vld_q;
      s2_gx_d      = s2_gx_q;
      s2_gy_d      = s2_gy_q;
      s2_mag_d     = s2_mag_q;
      s2_bin_d     = s2_bin_q;
      border_cnt_d = border_cnt_q;

      if (s1_adv) begin
         s1_vld_d = 1'b0;
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            s2_gx_d  = s1_gx_q;
            s2_gy_d  = s1_gy_q;
            s2_mag_d = mag_c;
            s2_bin_d = bin_c;
         end
      end

      if (k_fire && !k_border) begin
         s1_vld_d = 1'b1;
         s1_gx_d  = gx_in;
         s1_gy_d  = gy_in;
      end

      if (k_fire && k_border && border_cnt_q != 16'hFFFF)
         border_cnt_d = border_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q     <= 1'b0;
         s1_gx_q      <= '0;
         s1_gy_q      <= '0;
         s2_vld_q     <= 1'b0;
         s2_gx_q      <= '0;
         s2_gy_q      <= '0;
         s2_mag_q     <= '0;
         s2_bin_q     <= '0;
         border_cnt_q <= '0;
      end else begin
         s1_vld_q     <= s1_vld_d;
         s1_gx_q      <= s1_gx_d;
         s1_gy_q      <= s1_gy_d;
         s2_vld_q     <= s2_vld_d;
         s2_gx_q      <= s2_gx_d;
         s2_gy_q      <= s2_gy_d;
         s2_mag_q     <= s2_mag_d;
         s2_bin_q     <= s2_bin_d;
         border_cnt_q <= border_cnt_d;
      end
   end

   assign g_valid    = s2_vld_q;
   assign g_gx       = s2_gx_q;
   assign g_gy       = s2_gy_q;
   assign g_mag      = s2_mag_q;
   assign g_bin      = s2_bin_q;
   assign border_cnt = border_cnt_q;

endmodule

// File: tb/tb_gradient_bin.sv
// Bench for gradient_bin: directed vector table, stall/border/reset sequences,
// and a randomized stream scored against an arithmetic reference model.
module tb_gradient_bin;
   localparam int PW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              k_valid, k_ready, k_border;
   logic [9*PW-1:0]   kernel;
   logic              g_valid, g_ready;
   logic [PW:0]       g_gx, g_gy, g_mag;
   logic [3:0]        g_bin;
   logic [15:0]       border_cnt;

   always #5 clk = ~clk;

   gradient_bin #(.PIXEL_WIDTH(PW)) dut (
      .clk(clk), .rst(rst), .k_valid(k_valid), .k_ready(k_ready), .kernel(kernel),
      .k_border(k_border), .g_valid(g_valid), .g_ready(g_ready), .g_gx(g_gx),
      .g_gy(g_gy), .g_mag(g_mag), .g_bin(g_bin), .border_cnt(border_cnt)
   );

   typedef struct { int gx; int gy; int mag; int bin; } res_t;
   typedef struct { int p10; int p12; int p01; int p21; int gx; int gy; int mag; int bin; } vec_t;

   int   n_chk = 0;
   int   n_pass = 0;
   res_t exp_q[$];

   task automatic chk(input string name, input int got, input int expv);
      n_chk++;
      if (got == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, expv);
   endtask

   task automatic chk_res(input string name, input res_t e);
      int gx, gy;
      gx = $signed(g_gx);
      gy = $signed(g_gy);
      n_chk++;
      if (gx == e.gx && gy == e.gy && int'(g_mag) == e.mag && int'(g_bin) == e.bin) n_pass++;
      else $display("FAIL %s: got gx=%0d gy=%0d mag=%0d bin=%0d expected gx=%0d gy=%0d mag=%0d bin=%0d",
                    name, gx, gy, g_mag, g_bin, e.gx, e.gy, e.mag, e.bin);
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Reference: orientation from counting Q8 tangent thresholds in the folded half-plane.
   function automatic res_t model(input logic [9*PW-1:0] k);
      res_t r;
      int   th[4];
      int   fx, fy, cnt;
      th[0] = 93; th[1] = 215; th[2] = 443; th[3] = 1452;
      r.gx  = int'(k[5*PW +: PW]) - int'(k[3*PW +: PW]);
      r.gy  = int'(k[7*PW +: PW]) - int'(k[1*PW +: PW]);
      r.mag = iabs(r.gx) + iabs(r.gy);
      fx    = (r.gy < 0) ? -r.gx : r.gx;
      fy    = iabs(r.gy);
      cnt   = 0;
      for (int i = 0; i < 4; i++)
         if (fy * 256 >= iabs(fx) * th[i]) cnt++;
      if (r.gx == 0 && r.gy == 0) r.bin = 0;
      else if (fx < 0)            r.bin = 8 - cnt;
      else                        r.bin = cnt;
      return r;
   endfunction

   function automatic logic [9*PW-1:0] mk(input int p10, input int p12, input int p01, input int p21);
      logic [9*PW-1:0] k;
      for (int i = 0; i < 9; i++) k[i*PW +: PW] = PW'($urandom_range(0, 255));
      k[3*PW +: PW] = PW'(p10);
      k[5*PW +: PW] = PW'(p12);
      k[1*PW +: PW] = PW'(p01);
      k[7*PW +: PW] = PW'(p21);
      return k;
   endfunction

   function automatic logic [9*PW-1:0] rnd_win();
      return mk($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
   endfunction

   task automatic do_reset();
      rst = 1'b1; k_valid = 1'b0; k_border = 1'b0; g_ready = 1'b0; kernel = '0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   vec_t            vt[8];
   logic [9*PW-1:0] win[5];
   res_t            e, frozen;
   int              acc, got, seen, bexp;

   initial begin
      vt[0] = '{10, 50, 20, 20,   40,    0,  40, 0};
      vt[1] = '{7,  7,  0,  30,    0,   30,  30, 4};
      vt[2] = '{50, 10, 0,  10,  -40,   10,  50, 8};
      vt[3] = '{0,  20, 20, 0,    20,  -20,  40, 6};
      vt[4] = '{5,  5,  5,  5,     0,    0,   0, 0};
      vt[5] = '{0,  255, 0, 255, 255,  255, 510, 2};
      vt[6] = '{255, 0, 255, 0, -255, -255, 510, 2};
      vt[7] = '{1,  0,  0,  0,    -1,    0,   1, 8};

      rst = 1'b1; k_valid = 1'b0; k_border = 1'b0; g_ready = 1'b0; kernel = '0;
      #1;
      chk("rst_g_valid", g_valid, 0);
      chk("rst_border_cnt", border_cnt, 0);
      chk("rst_mag", g_mag, 0);
      do_reset();
      chk("post_rst_k_ready", k_ready, 1);

      // Directed vectors, one at a time, checking exact two-cycle latency.
      g_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         kernel = mk(vt[i].p10, vt[i].p12, vt[i].p01, vt[i].p21);
         k_valid = 1'b1;
         @(posedge clk); #1;
         k_valid = 1'b0;
         chk($sformatf("vec%0d_lat1", i), g_valid, 0);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_valid", i), g_valid, 1);
         e = '{vt[i].gx, vt[i].gy, vt[i].mag, vt[i].bin};
         chk_res($sformatf("vec%0d", i), e);
      end

      // Stall: output blocked, five windows offered.
      do_reset();
      g_ready = 1'b0; acc = 0;
      for (int i = 0; i < 5; i++) begin
         win[i] = rnd_win();
         kernel = win[i]; k_valid = 1'b1;
         #1;
         if (k_ready) begin acc++; exp_q.push_back(model(win[i])); end
         @(posedge clk); #1;
      end
      k_valid = 1'b0;
      chk("stall_accepted", acc, 2);
      chk("stall_k_ready", k_ready, 0);
      chk("stall_g_valid", g_valid, 1);
      frozen = model(win[0]);
      repeat (3) @(posedge clk);
      #1;
      chk_res("stall_frozen", frozen);
      g_ready = 1'b1; got = 0;
      for (int c = 0; c < 6; c++) begin
         if (g_valid) begin
            got++;
            if (exp_q.size() > 0) chk_res("stall_drain", exp_q.pop_front());
            else chk("stall_extra", got, 2);
         end
         @(posedge clk); #1;
      end
      chk("stall_results", got, 2);

      // Border windows interleaved with valid ones.
      do_reset();
      g_ready = 1'b1; got = 0;
      for (int i = 0; i < 5; i++) begin
         kernel = rnd_win(); k_valid = 1'b1; k_border = (i % 2 == 0);
         if (!k_border) exp_q.push_back(model(kernel));
         #1;
         if (g_valid) begin got++; if (exp_q.size() > 0) chk_res("border_res", exp_q.pop_front()); end
         @(posedge clk); #1;
      end
      k_valid = 1'b0; k_border = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (g_valid) begin got++; if (exp_q.size() > 0) chk_res("border_res", exp_q.pop_front()); end
         @(posedge clk); #1;
      end
      chk("border_results", got, 2);
      chk("border_cnt3", border_cnt, 3);

      // Saturation.
      do_reset();
      g_ready = 1'b1; k_valid = 1'b1; k_border = 1'b1; seen = 0;
      for (int c = 0; c < 70000; c++) begin
         @(posedge clk); #1;
         if (g_valid) seen = 1;
      end
      k_valid = 1'b0; k_border = 1'b0;
      chk("sat_no_g_valid", seen, 0);
      chk("sat_border_cnt", border_cnt, 16'hFFFF);

      // Asynchronous reset with both stages full.
      do_reset();
      g_ready = 1'b0;
      kernel = rnd_win(); k_valid = 1'b1; k_border = 1'b1;
      @(posedge clk); #1;
      k_border = 1'b0;
      kernel = rnd_win();
      @(posedge clk); #1;
      kernel = rnd_win();
      @(posedge clk); #1;
      k_valid = 1'b0;
      chk("pre_rst_g_valid", g_valid, 1);
      chk("pre_rst_k_ready", k_ready, 0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_g_valid", g_valid, 0);
      chk("async_rst_border_cnt", border_cnt, 0);
      @(posedge clk); #1 rst = 1'b0;
      g_ready = 1'b1;
      win[0] = mk(3, 200, 100, 40);
      kernel = win[0]; k_valid = 1'b1;
      @(posedge clk); #1;
      k_valid = 1'b0;
      chk("post_rst_no_stale", g_valid, 0);
      @(posedge clk); #1;
      chk("post_rst_valid", g_valid, 1);
      chk_res("post_rst_first", model(win[0]));
      @(posedge clk); #1;

      // Randomized stream against the reference model.
      do_reset();
      bexp = 0;
      for (int c = 0; c < 2000; c++) begin
         k_valid  = ($urandom_range(0, 3) != 0);
         k_border = ($urandom_range(0, 7) == 0);
         g_ready  = ($urandom_range(0, 3) != 0);
         kernel   = rnd_win();
         #1;
         if (g_valid && g_ready) begin
            if (exp_q.size() > 0) chk_res("rand_res", exp_q.pop_front());
            else chk("rand_spurious", g_valid, 0);
         end
         if (k_valid && k_ready) begin
            if (k_border) bexp++;
            else exp_q.push_back(model(kernel));
         end
         @(posedge clk); #1;
      end
      k_valid = 1'b0; g_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (g_valid) begin
            if (exp_q.size() > 0) chk_res("rand_drain", exp_q.pop_front());
            else chk("rand_spurious", g_valid, 0);
         end
         @(posedge clk); #1;
      end
      chk("rand_leftover", exp_q.size(), 0);
      chk("rand_border_cnt", border_cnt, bexp);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/gradient_bin.md
GRADIENT_BIN -- requirements
Module: gradient_bin

Interface
REQ-001 The module SHALL have parameter PIXEL_WIDTH, default 8, giving the unsigned pixel width; the window is fixed at 3x3.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 k_valid  input  1  a window is presented on kernel.
REQ-005 k_ready  output  1  the module accepts the presented window this cycle.
REQ-006 kernel  input  9*PIXEL_WIDTH  window; element (r,c) occupies bits (r*3+c)*PIXEL_WIDTH +: PIXEL_WIDTH; r=0 is the top row and c=0 is the left column.
REQ-007 k_border  input  1  the presented window straddles a row or frame boundary and is invalid.
REQ-008 g_valid  output  1  a gradient result is presented.
REQ-009 g_ready  input  1  the downstream block accepts the result.
REQ-010 g_gx  output  PIXEL_WIDTH+1  signed horizontal gradient.
REQ-011 g_gy  output  PIXEL_WIDTH+1  signed vertical gradient.
REQ-012 g_mag  output  PIXEL_WIDTH+1  unsigned |gx|+|gy|.
REQ-013 g_bin  output  4  unsigned orientation bin, 0..8, 20 degrees per bin over 0..180.
REQ-014 border_cnt  output  16  saturating count of windows dropped as border windows.

Function
REQ-015 A window SHALL be transferred on a rising edge where k_valid and k_ready are both 1; likewise a result SHALL be transferred where g_valid and g_ready are both 1.
REQ-016 The datapath SHALL be two registered stages: S1 holds gx and gy; S2 holds gx, gy, mag and bin and drives the g_* outputs.
REQ-017 k_ready SHALL equal !S1_valid || S1_advance, where S1_advance = !S2_valid || g_ready; there SHALL be no combinational path from k_valid to k_ready.
REQ-018 A transferred window with k_border=1 SHALL be consumed without entering S1, and border_cnt SHALL increment by 1, saturating at 16'hFFFF.
REQ-019 gx SHALL equal (1,2)-(1,0) and gy SHALL equal (2,1)-(0,1), each sign-extended to PIXEL_WIDTH+1 bits.
REQ-020 mag SHALL equal |gx|+|gy|; the maximum is 2*(2^PIXEL_WIDTH-1), which fits in PIXEL_WIDTH+1 bits without overflow.
REQ-021 Fold: if gy<0, both gx and gy SHALL be negated before binning, so gy>=0 and the angle lies in [0,180].
REQ-022 Define count as the number of thresholds T in {93,215,443,1452} for which |gy|*256 >= |gx|*T. These are Q8 tan(20/40/60/80 deg). The comparison SHALL use at least 20-bit unsigned products for PIXEL_WIDTH=8.
REQ-023 After the fold, g_bin SHALL be count when gx>=0 and 8-count when gx<0.
REQ-024 gx=gy=0 SHALL yield bin 0 and mag 0.
REQ-025 Latency SHALL be 2 cycles: a window accepted at edge N with g_ready held at 1 SHALL be presented with g_valid=1 after edge N+2.
REQ-026 Throughput SHALL be one window per cycle while g_ready=1.
REQ-027 While g_valid=1 and g_ready=0, all g_* outputs SHALL hold stable, S1 SHALL hold, and k_ready SHALL fall once S1 is occupied.
REQ-028 When S2 is consumed in the same cycle S1 loads a new window, no result SHALL be lost or duplicated.
REQ-029 k_valid=1 with k_border=1 SHALL never produce g_valid, including during stall.
REQ-030 Result ordering SHALL equal window acceptance order.

Reset
REQ-031 Asserting rst SHALL immediately clear the following, independent of clk: S1_valid, S2_valid, g_valid, g_gx, g_gy, g_mag, g_bin and border_cnt.
REQ-032 After reset, k_ready SHALL be 1.
REQ-033 Asserting rst mid-stream SHALL discard all in-flight results; the first window accepted after release SHALL be the first result emitted.

Verification
REQ-034 Row 1 = [10,x,50], (0,1)=(2,1)=20, g_ready=1 -> after 2 cycles gx=40, gy=0, mag=40, bin=0.
REQ-035 (1,0)=(1,2)=7, (0,1)=0, (2,1)=30 -> gx=0, gy=30, mag=30, bin=4; then gx=-40, gy=10 -> bin=8, mag=50.
REQ-036 gx=20, gy=-20 -> fold gives bin=6, mag=40, with g_gx=20 and g_gy=-20 reported unfolded.
REQ-037 Stream 5 windows while g_ready=0 -> g_valid=1, outputs frozen, k_ready=0 after 2 accepted; then raise g_ready -> 2 results in order, no loss.
REQ-038 Send 3 border windows interleaved with 2 valid windows -> exactly 2 results, border_cnt=3; 70000 border windows -> border_cnt=16'hFFFF.
REQ-039 Assert rst with S1 and S2 full -> g_valid=0 and border_cnt=0 immediately; post-release window A is emitted first.
